// File: rtl/types_pkg.sv
// Command-set definitions shared by the command stream arbiter and the command decoder.
package types_pkg;

   localparam logic [7:0] OP_PAIR     = 8'hA0;
   localparam logic [7:0] OP_TRIANGLE = 8'hA1;
   localparam logic [7:0] OP_SCENE    = 8'hB0;

   localparam int unsigned TRI_PAYLOAD_BYTES   = 9;
   localparam int unsigned SCENE_PAYLOAD_BYTES = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_PAD  = 2'd2
   } arb_state_e;

   // Total command length in bytes, opcode included; unknown opcodes are single-byte.
   function automatic logic [7:0] cmd_length_bytes(input logic [7:0] opcode);
      case (opcode)
         OP_PAIR:     cmd_length_bytes = 8'd2;
         OP_TRIANGLE: cmd_length_bytes = 8'(1 + TRI_PAYLOAD_BYTES);
         OP_SCENE:    cmd_length_bytes = 8'(1 + SCENE_PAYLOAD_BYTES);
         default:     cmd_length_bytes = 8'd1;
      endcase
   endfunction

endpackage

// File: rtl/cmd_stream_arbiter.sv
// Merges two command byte streams, switching source only at command boundaries.
// Zero-latency combinational forwarding; a stalled locked source is padded out with 0x00 after a timeout.
module cmd_stream_arbiter
   import types_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       s0_valid,
   output logic       s0_ready,
   input  logic [7:0] s0_data,
   input  logic       s1_valid,
   output logic       s1_ready,
   input  logic [7:0] s1_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic [7:0] m_data,
   output logic       m_src,
   output logic       busy,
   output logic       timeout_pulse
);

   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   arb_state_e    state_q, state_d;
   logic          ptr_q, ptr_d;       // last served source
   logic          lock_q, lock_d;
   logic [7:0]    left_q, left_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pulse_q, pulse_d;

   logic          grant;
   logic          src_sel;
   logic          src_valid;
   logic [7:0]    src_data;
   logic [7:0]    op_left;
   logic          fwd_ready;
   logic          m_fire;

   always_comb begin
      grant = 1'b0;
      if (s0_valid && s1_valid) begin
         grant = ~ptr_q;
      end else if (s1_valid) begin
         grant = 1'b1;
      end
   end

   assign src_sel   = (state_q == ST_IDLE) ? grant : lock_q;
   assign src_valid = src_sel ? s1_valid : s0_valid;
   assign src_data  = src_sel ? s1_data : s0_data;
   assign op_left   = cmd_length_bytes(src_data) - 8'd1;

   // Outputs are gated by rstn so nothing leaks through while reset is held.
   assign m_valid       = rstn && ((state_q == ST_PAD) || src_valid);
   assign m_data        = (state_q == ST_PAD) ? 8'h00 : src_data;
   assign m_src         = rstn && src_sel;
   assign fwd_ready     = rstn && (state_q != ST_PAD) && m_ready;
   assign s0_ready      = fwd_ready && !src_sel;
   assign s1_ready      = fwd_ready && src_sel;
   assign busy          = (state_q != ST_IDLE);
   assign timeout_pulse = pulse_q;
   assign m_fire        = m_valid && m_ready;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      lock_d  = lock_q;
      left_d  = left_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (m_fire) begin
               left_d = op_left;
               if (op_left == 8'd0) begin
                  ptr_d = ~ptr_q;
               end else begin
                  state_d = ST_PASS;
                  lock_d  = grant;
                  cnt_d   = '0;
               end
            end
         end
         ST_PASS: begin
            if (m_fire) begin
               cnt_d = '0;
               if (left_q <= 8'd1) begin
                  state_d = ST_IDLE;
                  left_d  = 8'd0;
                  ptr_d   = lock_q;
               end else begin
                  left_d = left_q - 8'd1;
               end
            end else if (!src_valid) begin
               // Only an absent source counts as a stall; downstream backpressure never does.
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_PAD;
                  pulse_d = 1'b1;
               end
            end
         end
         ST_PAD: begin
            if (m_fire) begin
               if (left_q <= 8'd1) begin
                  state_d = ST_IDLE;
                  left_d  = 8'd0;
                  ptr_d   = lock_q;
               end else begin
                  left_d = left_q - 8'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         ptr_q   <= 1'b1;
         lock_q  <= 1'b0;
         left_q  <= 8'd0;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
         left_q  <= left_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
// Randomized and directed bench for cmd_stream_arbiter with a per-source expected-byte scoreboard.
module tb_cmd_stream_arbiter;

   localparam int TO = 32;

   logic       clk = 1'b0;
   logic       rstn;
   logic       s0_valid, s0_ready, s1_valid, s1_ready;
   logic [7:0] s0_data, s1_data;
   logic       m_valid, m_ready, m_src, busy, timeout_pulse;
   logic [7:0] m_data;

   cmd_stream_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rstn(rstn),
      .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
      .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_src(m_src), .busy(busy), .timeout_pulse(timeout_pulse)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int pulse_cnt = 0;

   logic [7:0] src_q0[$], src_q1[$];
   logic [7:0] exp_q0[$], exp_q1[$];
   int  rem0 = 0, rem1 = 0;
   int  vld_pct = 100, mr_pct = 100;
   bit  last_pulse;

   typedef struct {
      int         cyc;
      bit         src;
      logic [7:0] data;
      bit         busy;
   } log_t;
   log_t hlog[$];

   // Command-level view of the merged stream, kept by the monitor.
   int  cur_rem = 0;
   bit  cur_src = 1'b0;
   bit  last_srv = 1'b1;
   bit  padding = 1'b0;

   function automatic int tb_len(input logic [7:0] op);
      case (op)
         8'hA0:   return 2;
         8'hA1:   return 10;
         8'hB0:   return 33;
         default: return 1;
      endcase
   endfunction

   function automatic logic [7:0] rand_op();
      case ($urandom_range(4))
         0:       return 8'hA0;
         1:       return 8'hA1;
         2:       return 8'hB0;
         3:       return 8'h42;
         default: return 8'($urandom_range(255));
      endcase
   endfunction

   function automatic int log_srcs();
      int v = 0;
      foreach (hlog[i]) v = v * 2 + int'(hlog[i].src);
      return v;
   endfunction

   task automatic chk(input bit ok, input string name, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_both(input int s, input logic [7:0] b);
      if (s == 0) begin src_q0.push_back(b); exp_q0.push_back(b); end
      else        begin src_q1.push_back(b); exp_q1.push_back(b); end
   endtask

   task automatic add_cmd(input int s, input logic [7:0] op);
      int n;
      n = tb_len(op);
      push_both(s, op);
      for (int i = 1; i < n; i++) push_both(s, 8'($urandom_range(255)));
   endtask

   // One clock: note handshakes, then present the next bytes after the edge.
   task automatic step();
      bit f0, f1;
      logic [7:0] b;
      @(negedge clk);
      f0 = s0_valid && s0_ready;
      f1 = s1_valid && s1_ready;
      last_pulse = timeout_pulse;
      @(posedge clk);
      #1;
      if (f0 && src_q0.size() != 0) begin
         b = src_q0.pop_front();
         rem0 = (rem0 == 0) ? tb_len(b) - 1 : rem0 - 1;
      end
      if (f1 && src_q1.size() != 0) begin
         b = src_q1.pop_front();
         rem1 = (rem1 == 0) ? tb_len(b) - 1 : rem1 - 1;
      end
      s0_valid = (src_q0.size() != 0) && (rem0 != 0 || int'($urandom_range(99)) < vld_pct);
      s1_valid = (src_q1.size() != 0) && (rem1 != 0 || int'($urandom_range(99)) < vld_pct);
      s0_data  = (src_q0.size() != 0) ? src_q0[0] : 8'($urandom_range(255));
      s1_data  = (src_q1.size() != 0) ? src_q1[0] : 8'($urandom_range(255));
      m_ready  = int'($urandom_range(99)) < mr_pct;
   endtask

   task automatic drain(input int bound, input string name);
      int n = 0;
      while ((exp_q0.size() + exp_q1.size()) != 0 && n < bound) begin
         step();
         n++;
      end
      chk(exp_q0.size() == 0 && exp_q1.size() == 0, name, exp_q0.size() + exp_q1.size(), 0);
   endtask

   // Monitor / scoreboard
   logic [7:0] exp_b;
   bit         g;
   logic       exp_v;
   int         nlen;
   always @(negedge clk) begin
      cyc++;
      if (!rstn) begin
         chk(m_valid == 1'b0, "rst_m_valid", m_valid, 0);
         chk(!s0_ready && !s1_ready, "rst_s_ready", {s1_ready, s0_ready}, 0);
         chk(busy == 1'b0, "rst_busy", busy, 0);
         chk(m_src == 1'b0, "rst_m_src", m_src, 0);
         chk(timeout_pulse == 1'b0, "rst_pulse", timeout_pulse, 0);
         cur_rem  = 0;
         last_srv = 1'b1;
         padding  = 1'b0;
      end else begin
         if (timeout_pulse) begin
            pulse_cnt++;
            chk(cur_rem != 0 && !padding, "pulse_in_cmd", cur_rem, 1);
            padding = 1'b1;
         end
         chk(busy == (cur_rem != 0), "busy", busy, cur_rem != 0);
         if (cur_rem != 0) begin
            chk(m_src == cur_src, "m_src_locked", m_src, cur_src);
            exp_v = padding ? 1'b1 : (cur_src ? s1_valid : s0_valid);
            chk(m_valid == exp_v, "m_valid_locked", m_valid, exp_v);
            if (padding)
               chk(!s0_ready && !s1_ready, "pad_s_ready", {s1_ready, s0_ready}, 0);
            else
               chk({s1_ready, s0_ready} == (cur_src ? {m_ready, 1'b0} : {1'b0, m_ready}),
                   "ready_locked", {s1_ready, s0_ready}, cur_src ? {m_ready, 1'b0} : {1'b0, m_ready});
         end else begin
            if (s0_valid && s1_valid) g = !last_srv;
            else                      g = s1_valid;
            chk(m_valid == (s0_valid || s1_valid), "m_valid_idle", m_valid, s0_valid || s1_valid);
            chk(m_src == g, "m_src_idle", m_src, g);
            chk({s1_ready, s0_ready} == (g ? {m_ready, 1'b0} : {1'b0, m_ready}),
                "ready_idle", {s1_ready, s0_ready}, g ? {m_ready, 1'b0} : {1'b0, m_ready});
         end
         if (m_valid && m_ready) begin
            if ((m_src ? exp_q1.size() : exp_q0.size()) == 0) begin
               chk(1'b0 == m_valid, "unexpected_byte", m_data, m_src);
            end else begin
               if (m_src) exp_b = exp_q1.pop_front();
               else       exp_b = exp_q0.pop_front();
               chk(m_data == exp_b, "m_data", m_data, exp_b);
            end
            hlog.push_back('{cyc, m_src, m_data, busy});
            if (cur_rem == 0) begin
               nlen = tb_len(m_data) - 1;
               if (nlen == 0) last_srv = !last_srv;
               else begin cur_rem = nlen; cur_src = m_src; end
            end else begin
               cur_rem--;
               if (cur_rem == 0) begin
                  last_srv = cur_src;
                  padding  = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, p0;
      rstn = 1'b0;
      s0_valid = 1'b1; s1_valid = 1'b1;
      s0_data = 8'hA0; s1_data = 8'hA0;
      m_ready = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      rstn = 1'b1;
      s0_valid = 1'b0; s1_valid = 1'b0;
      repeat (2) step();

      // Tie after reset: s0 first, whole command, then s1.
      hlog.delete();
      add_cmd(0, 8'hA0); add_cmd(1, 8'hA0);
      drain(200, "drain_tie");
      chk(hlog.size() == 4 && log_srcs() == 3, "tie_order", log_srcs(), 3);
      hlog.delete();
      push_both(0, 8'h42); push_both(1, 8'h42);
      drain(200, "drain_tie2");
      chk(hlog.size() == 2 && log_srcs() == 1, "tie_after_s1", log_srcs(), 1);

      // Two-byte command on consecutive cycles, busy only on the second.
      hlog.delete();
      push_both(0, 8'hA0); push_both(0, 8'h05);
      drain(200, "drain_a0");
      chk(hlog.size() == 2, "a0_count", hlog.size(), 2);
      if (hlog.size() == 2) begin
         chk(hlog[1].cyc - hlog[0].cyc == 1, "a0_back_to_back", hlog[1].cyc - hlog[0].cyc, 1);
         chk(!hlog[0].busy && hlog[1].busy, "a0_busy", {hlog[0].busy, hlog[1].busy}, 1);
      end
      chk(busy == 1'b0, "a0_idle_after", busy, 0);

      // Single-byte command from s1, then s0 immediately after.
      hlog.delete();
      push_both(1, 8'h42); push_both(0, 8'hA0); push_both(0, 8'h11);
      drain(200, "drain_1byte");
      chk(hlog.size() == 3 && log_srcs() == 4, "1byte_order", log_srcs(), 4);
      if (hlog.size() == 3) begin
         chk(hlog[1].cyc - hlog[0].cyc == 1, "1byte_next_cycle", hlog[1].cyc - hlog[0].cyc, 1);
         chk(!hlog[0].busy, "1byte_busy", hlog[0].busy, 0);
      end

      // Stalled triangle: timeout, zero padding, then pending s1 command.
      hlog.delete(); p0 = pulse_cnt;
      push_both(0, 8'hA1);
      for (int i = 1; i <= 3; i++) push_both(0, 8'(i));
      for (int i = 0; i < 6; i++) exp_q0.push_back(8'h00);
      n = 0;
      while (src_q0.size() != 0 && n < 100) begin step(); n++; end
      add_cmd(1, 8'hA0);
      n = 0;
      while (n < TO + 50) begin
         step();
         if (last_pulse) break;
         n++;
      end
      chk(n == TO, "timeout_latency", n, TO);
      drain(300, "drain_timeout");
      chk(pulse_cnt - p0 == 1, "timeout_pulse_count", pulse_cnt - p0, 1);
      chk(hlog.size() == 12 && log_srcs() == 3, "pad_then_s1", log_srcs(), 3);
      rem0 = 0;

      // Long downstream stall never times out.
      hlog.delete(); p0 = pulse_cnt;
      add_cmd(0, 8'hA1);
      n = 0;
      while (src_q0.size() > 7 && n < 100) begin step(); n++; end
      mr_pct = 0; m_ready = 1'b0;
      repeat (5000) step();
      chk(hlog.size() == 3, "stall_no_progress", hlog.size(), 3);
      chk(pulse_cnt == p0, "stall_no_timeout", pulse_cnt - p0, 0);
      mr_pct = 100;
      drain(200, "drain_stall");
      chk(hlog.size() == 10, "stall_complete", hlog.size(), 10);

      // Randomized traffic.
      p0 = pulse_cnt; vld_pct = 60; mr_pct = 70;
      for (int i = 0; i < 30; i++) begin
         add_cmd(0, rand_op());
         add_cmd(1, rand_op());
      end
      drain(20000, "drain_random");
      chk(pulse_cnt == p0, "random_no_timeout", pulse_cnt - p0, 0);
      vld_pct = 100; mr_pct = 100;

      // Reset in the middle of a locked command.
      add_cmd(1, 8'hA0);
      add_cmd(0, 8'hB0);
      n = 0;
      while (src_q0.size() > 28 && n < 100) begin step(); n++; end
      rstn = 1'b0;
      #1;
      chk(m_valid == 1'b0, "rst_mid_m_valid", m_valid, 0);
      chk(busy == 1'b0, "rst_mid_busy", busy, 0);
      repeat (3) @(negedge clk);
      src_q0.delete(); src_q1.delete(); exp_q0.delete(); exp_q1.delete();
      rem0 = 0; rem1 = 0;
      s0_valid = 1'b0; s1_valid = 1'b0;
      hlog.delete();
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (5) step();
      chk(hlog.size() == 0, "no_pad_after_reset", hlog.size(), 0);
      add_cmd(0, 8'hA0); add_cmd(1, 8'hA0);
      drain(200, "drain_post_reset");
      chk(hlog.size() == 4 && log_srcs() == 3, "post_reset_tie", log_srcs(), 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cmd_stream_arbiter.md
CMD_STREAM_ARBITER -- requirements
Module: cmd_stream_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1024, cycles a locked source may stall mid-command before abort.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 s0_valid / s0_ready / s0_data  in / out / in  1/1/8  command byte stream from source 0 (host link).
REQ-005 s1_valid / s1_ready / s1_data  in / out / in  1/1/8  command byte stream from source 1 (debug link).
REQ-006 m_valid / m_ready / m_data  out / in / out  1/1/8  merged byte stream to the command decoder input.
REQ-007 m_src  output  1  index of the source currently driving m_data.
REQ-008 busy  output  1  high while a multi-byte command is locked (PASS or PAD).
REQ-009 timeout_pulse  output  1  one-cycle strobe when a locked command is aborted.

Function
REQ-010 The block SHALL interleave sources only at command boundaries: all bytes of one command come from a single source.
REQ-011 A transfer SHALL occur on any port only when valid and ready are both high in the same cycle.
REQ-012 Forwarding SHALL be combinational with zero latency: m_valid/m_data follow the granted source, and its ready follows m_ready; the non-granted source ready SHALL be 0.
REQ-013 States: IDLE, PASS, PAD.
REQ-014 IDLE: grant goes to the single valid source; if both are valid, grant goes to the source opposite the round-robin pointer's last-served source; if neither is valid, m_valid=0.
REQ-015 IDLE opcode handshake: left <= cmd_length_bytes(opcode)-1; if left is 0 (unknown opcode or 1-byte command), stay in IDLE and toggle the pointer; otherwise go to PASS and lock the source.
REQ-016 Command lengths: 0xA0 -> 2, 0xA1 -> 1+triangle payload bytes, 0xB0 -> 1+scene payload bytes, other -> 1.
REQ-017 PASS: forward only the locked source; decrement left on each m handshake; the handshake with left==1 returns to IDLE and sets the pointer to the locked source.
REQ-018 Timeout counter: cleared on entering PASS and on every handshake; increments while in PASS with locked source valid=0; m_ready=0 stalls SHALL NOT increment it.
REQ-019 When the counter reaches TIMEOUT_CYCLES-1 and increments again, the block SHALL enter PAD and pulse timeout_pulse for exactly one cycle.
REQ-020 PAD: m_valid=1, m_data=0x00, both s*_ready=0, m_src=locked source; decrement left on each m handshake; the handshake with left==1 returns to IDLE and sets the pointer to the aborted source.
REQ-021 A source byte arriving in the same cycle the timeout fires SHALL NOT be accepted.
REQ-022 left is 8 bits unsigned and never underflows; the counter width is clog2(TIMEOUT_CYCLES)+1 and saturates.
REQ-023 busy = (state != IDLE); m_src in IDLE equals the current grant, or 0 when nothing is valid.

Reset
REQ-024 While rstn=0: state=IDLE, pointer indicates source 1 as last served (so source 0 wins the first tie), left=0, counter=0, timeout_pulse=0.
REQ-025 While rstn=0: m_valid=0, s0_ready=0, s1_ready=0, busy=0, m_src=0.
REQ-026 Reset mid-command SHALL abandon the command without padding.

Structure
REQ-027 The opcode constants and the cmd_length_bytes function SHALL reside in types_pkg and be shared with the command decoder.
REQ-028 TIMEOUT_CYCLES SHALL be a module parameter, not a package constant.
REQ-029 The block SHALL be a single module with no sub-module; the round-robin pick is inline logic.

Verification
REQ-030 s0 sends A0,05 with m_ready=1 -> m sees A0,05 on consecutive cycles, m_src=0, busy high for one cycle, then IDLE.
REQ-031 After reset, s0 and s1 both present A0 -> s0 command completes first with no s1 byte interleaved, then the s1 command; next tie goes to s0.
REQ-032 s1 sends 0x42 -> one byte forwarded, busy stays 0, pointer toggles, the next s0 byte is granted the following cycle.
REQ-033 s0 sends A1 plus 3 payload bytes, then s0_valid=0 -> after TIMEOUT_CYCLES stall cycles, timeout_pulse=1 once, the remaining payload is emitted as 0x00, then a pending s1 command is granted.
REQ-034 m_ready=0 for 5000 cycles mid-PASS with s0_valid=1 -> no timeout; the command completes intact when m_ready returns to 1.
REQ-035 rstn pulsed low mid-PASS -> m_valid=0 immediately, state IDLE, next tie granted to s0, no pad bytes emitted.
